// File: rtl/redirect_arbiter.sv
// rtl/redirect_arbiter.sv - oldest-first redirect arbiter with post-flush filtering window
// Picks one redirect per cycle (csr > oldest branch/mem) and suppresses stale younger redirects while the flush drains.
module redirect_arbiter #(
  parameter int NUM_BR       = 2,
  parameter int ROB_WIDTH    = 6,
  parameter int VADDR        = 39,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_BR-1:0]                 br_valid,
  input  logic [NUM_BR-1:0][ROB_WIDTH:0]    br_robidx,
  input  logic [NUM_BR-1:0][VADDR-1:0]      br_target,
  input  logic                              mem_valid,
  input  logic [ROB_WIDTH:0]                mem_robidx,
  input  logic [VADDR-1:0]                  mem_target,
  input  logic                              csr_valid,
  input  logic [ROB_WIDTH:0]                csr_robidx,
  input  logic [VADDR-1:0]                  csr_target,
  output logic                              out_valid,
  output logic [ROB_WIDTH:0]                out_robidx,
  output logic [VADDR-1:0]                  out_target,
  output logic [1:0]                        out_src,
  output logic                              busy,
  output logic [15:0]                       drop_cnt
);

  localparam int RW = ROB_WIDTH + 1;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES);
  localparam logic [1:0] SRC_BR  = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_CSR = 2'd2;

  typedef enum logic {IDLE, BLOCK} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [RW-1:0]    last_idx_q;
  logic             last_csr_q;
  logic             out_valid_q;
  logic [RW-1:0]    out_robidx_q;
  logic [VADDR-1:0] out_target_q;
  logic [1:0]       out_src_q;
  logic [15:0]      drop_cnt_q;
  logic [15:0]      drop_cnt_d;

  logic             cand_valid;
  logic [RW-1:0]    cand_idx;
  logic [VADDR-1:0] cand_target;
  logic [1:0]       cand_src;
  logic [3:0]       n_valid;
  logic [3:0]       n_drop;
  logic             accept;
  logic [16:0]      drop_sum;

  // The dir bit toggles on every ROB wrap, so a differing dir inverts the index comparison.
  function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    if (a[ROB_WIDTH] == b[ROB_WIDTH]) return a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0];
    else                              return a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0];
  endfunction

  // Strictly-older replacement keeps lower ports ahead on ties and branches ahead of mem.
  always_comb begin
    cand_valid  = 1'b0;
    cand_idx    = '0;
    cand_target = '0;
    cand_src    = SRC_BR;
    n_valid     = 4'(mem_valid) + 4'(csr_valid);
    for (int i = 0; i < NUM_BR; i++) begin
      n_valid = n_valid + 4'(br_valid[i]);
      if (br_valid[i] && (!cand_valid || older(br_robidx[i], cand_idx))) begin
        cand_valid  = 1'b1;
        cand_idx    = br_robidx[i];
        cand_target = br_target[i];
        cand_src    = SRC_BR;
      end
    end
    if (mem_valid && (!cand_valid || older(mem_robidx, cand_idx))) begin
      cand_valid  = 1'b1;
      cand_idx    = mem_robidx;
      cand_target = mem_target;
      cand_src    = SRC_MEM;
    end
    if (csr_valid) begin
      cand_valid  = 1'b1;
      cand_idx    = csr_robidx;
      cand_target = csr_target;
      cand_src    = SRC_CSR;
    end
  end

  // The candidate is the oldest non-csr request, so if it fails the window test every other one does too.
  always_comb begin
    if (state_q == IDLE) accept = cand_valid;
    else accept = cand_valid &&
                  ((cand_src == SRC_CSR) || (!last_csr_q && older(cand_idx, last_idx_q)));
    n_drop     = n_valid - 4'(accept);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_idx_q   <= '0;
      last_csr_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_robidx_q <= '0;
      out_target_q <= '0;
      out_src_q    <= SRC_BR;
      drop_cnt_q   <= '0;
    end else begin
      out_valid_q <= accept;
      drop_cnt_q  <= drop_cnt_d;
      if (accept) begin
        out_robidx_q <= cand_idx;
        out_target_q <= cand_target;
        out_src_q    <= cand_src;
        state_q      <= BLOCK;
        cnt_q        <= CNT_INIT;
        last_idx_q   <= cand_idx;
        last_csr_q   <= (cand_src == SRC_CSR);
      end else if (state_q == BLOCK) begin
        if (cnt_q <= 4'd1) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_robidx = out_robidx_q;
  assign out_target = out_target_q;
  assign out_src    = out_src_q;
  assign busy       = (state_q == BLOCK);
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_redirect_arbiter.sv
// tb/tb_redirect_arbiter.sv - directed scoreboard bench for redirect_arbiter
module tb_redirect_arbiter;

  localparam int NUM_BR = 2;
  localparam int RW     = 7;
  localparam int VA     = 39;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic [NUM_BR-1:0]            br_valid;
  logic [NUM_BR-1:0][RW-1:0]    br_robidx;
  logic [NUM_BR-1:0][VA-1:0]    br_target;
  logic                         mem_valid;
  logic [RW-1:0]                mem_robidx;
  logic [VA-1:0]                mem_target;
  logic                         csr_valid;
  logic [RW-1:0]                csr_robidx;
  logic [VA-1:0]                csr_target;
  logic                         out_valid;
  logic [RW-1:0]                out_robidx;
  logic [VA-1:0]                out_target;
  logic [1:0]                   out_src;
  logic                         busy;
  logic [15:0]                  drop_cnt;

  typedef struct {
    logic [RW-1:0] idx;
    logic [VA-1:0] tgt;
    logic [1:0]    src;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  redirect_arbiter #(.NUM_BR(2), .ROB_WIDTH(6), .VADDR(39), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_robidx(br_robidx), .br_target(br_target),
    .mem_valid(mem_valid), .mem_robidx(mem_robidx), .mem_target(mem_target),
    .csr_valid(csr_valid), .csr_robidx(csr_robidx), .csr_target(csr_target),
    .out_valid(out_valid), .out_robidx(out_robidx), .out_target(out_target),
    .out_src(out_src), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] ri(input logic dir, input logic [5:0] idx);
    return {dir, idx};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    br_valid   = '0;
    br_robidx  = '0;
    br_target  = '0;
    mem_valid  = 1'b0;
    mem_robidx = '0;
    mem_target = '0;
    csr_valid  = 1'b0;
    csr_robidx = '0;
    csr_target = '0;
  endtask

  task automatic push(input logic [RW-1:0] idx, input logic [VA-1:0] tgt, input logic [1:0] src);
    exp_t e;
    e.idx = idx;
    e.tgt = tgt;
    e.src = src;
    sb.push_back(e);
  endtask

  // Inputs are set at negedge; outputs are compared 1 time unit after the next posedge.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pulse_valid", 64'(out_valid), 64'd1);
      chk("pulse_robidx", 64'(out_robidx), 64'(e.idx));
      chk("pulse_target", 64'(out_target), 64'(e.tgt));
      chk("pulse_src", 64'(out_src), 64'(e.src));
    end else begin
      chk("no_pulse", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
  endtask

  task automatic idle4();
    clear();
    repeat (4) cycle();
    chk("settled_idle", 64'(busy), 64'd0);
  endtask

  task automatic br(input int p, input logic [RW-1:0] idx, input logic [VA-1:0] tgt);
    br_valid[p]  = 1'b1;
    br_robidx[p] = idx;
    br_target[p] = tgt;
  endtask

  initial begin
    clear();
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_robidx", 64'(out_robidx), 64'd0);
    chk("rst_target", 64'(out_target), 64'd0);
    chk("rst_src", 64'(out_src), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b1;
    cycle();

    // single branch, window of 3 cycles
    br(0, ri(0, 10), 39'h1000);
    push(ri(0, 10), 39'h1000, 2'd0);
    cycle();
    chk("single_busy1", 64'(busy), 64'd1);
    clear();
    cycle();
    chk("single_busy2", 64'(busy), 64'd1);
    chk("single_hold_idx", 64'(out_robidx), 64'(ri(0, 10)));
    cycle();
    chk("single_busy3", 64'(busy), 64'd1);
    cycle();
    chk("single_busy_off", 64'(busy), 64'd0);
    chk("single_drop", 64'(drop_cnt), 64'd0);

    // oldest of three
    br(0, ri(0, 20), 39'h2000);
    br(1, ri(0, 5), 39'h2100);
    mem_valid = 1'b1; mem_robidx = ri(0, 12); mem_target = 39'h3000;
    push(ri(0, 5), 39'h2100, 2'd0);
    cycle();
    chk("age_drop", 64'(drop_cnt), 64'd2);
    idle4();

    // tie: port 0 beats port 1 beats mem
    br(0, ri(0, 7), 39'hA000);
    br(1, ri(0, 7), 39'hB000);
    mem_valid = 1'b1; mem_robidx = ri(0, 7); mem_target = 39'hC000;
    push(ri(0, 7), 39'hA000, 2'd0);
    cycle();
    chk("tie_drop", 64'(drop_cnt), 64'd4);
    idle4();

    // window filter and older reissue
    br(0, ri(0, 10), 39'h1000);
    push(ri(0, 10), 39'h1000, 2'd0);
    cycle();
    clear();
    br(0, ri(0, 15), 39'h1500);
    cycle();
    chk("filter_drop", 64'(drop_cnt), 64'd5);
    clear();
    mem_valid = 1'b1; mem_robidx = ri(0, 4); mem_target = 39'h4000;
    push(ri(0, 4), 39'h4000, 2'd1);
    cycle();
    chk("reissue_busy1", 64'(busy), 64'd1);
    clear();
    cycle();
    chk("reissue_busy2", 64'(busy), 64'd1);
    cycle();
    chk("reissue_busy3", 64'(busy), 64'd1);
    cycle();
    chk("reissue_busy_off", 64'(busy), 64'd0);

    // csr preempts, then blocks all non-csr
    br(0, ri(0, 30), 39'h5000);
    push(ri(0, 30), 39'h5000, 2'd0);
    cycle();
    clear();
    csr_valid = 1'b1; csr_robidx = ri(0, 2); csr_target = 39'h8000_0000;
    push(ri(0, 2), 39'h8000_0000, 2'd2);
    cycle();
    clear();
    br(0, ri(0, 1), 39'h6000);
    cycle();
    chk("csr_block_drop", 64'(drop_cnt), 64'd6);
    chk("csr_block_busy", 64'(busy), 64'd1);
    idle4();

    // wrap-around: last {1,3}
    br(0, ri(1, 3), 39'h7000);
    push(ri(1, 3), 39'h7000, 2'd0);
    cycle();
    clear();
    br(0, ri(0, 2), 39'h7050);
    cycle();
    chk("wrap_drop", 64'(drop_cnt), 64'd7);
    clear();
    br(0, ri(1, 2), 39'h7100);
    push(ri(1, 2), 39'h7100, 2'd0);
    cycle();
    idle4();

    // asynchronous reset mid-window with an acceptable request pending
    br(0, ri(0, 9), 39'h9000);
    push(ri(0, 9), 39'h9000, 2'd0);
    cycle();
    clear();
    br(0, ri(0, 1), 39'h9100);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_robidx", 64'(out_robidx), 64'd0);
    chk("arst_target", 64'(out_target), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    clear();
    rst = 1'b1;
    repeat (3) cycle();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
